// File: rtl/rv32_pkg.sv
// Shared RV32I datapath types: writeback FSM states, load funct3 encodings and
// the load legality rule.
package rv32_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOAD_WAIT = 2'd1,
        WRITE     = 2'd2
    } wb_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // A load is legal when funct3 is a defined width and the address is naturally aligned.
    function automatic logic load_legal(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            F3_LB, F3_LBU: return 1'b1;
            F3_LH, F3_LHU: return ~a[0];
            F3_LW:         return a == 2'b00;
            default:       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/writeback_unit_if.sv
// Writeback bus: retire handshake, data-memory read port and register-file write port.
// Forwarding signals exist only when WB_FORWARD_EN is defined.
interface writeback_unit_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
);
    logic              valid_in;
    logic              ready_out;
    logic [REG_AW-1:0] rd_in;
    logic              reg_write_in;
    logic              is_load;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   alu_result;
    logic              mem_read;
    logic [XLEN-1:0]   mem_address;
    logic              mem_ack;
    logic [XLEN-1:0]   mem_rdata;
    logic              reg_write;
    logic [REG_AW-1:0] reg_address;
    logic [XLEN-1:0]   reg_data;
    logic              load_fault;
`ifdef WB_FORWARD_EN
    logic [REG_AW-1:0] fwd_addr1;
    logic [REG_AW-1:0] fwd_addr2;
    logic [XLEN-1:0]   fwd_rf1;
    logic [XLEN-1:0]   fwd_rf2;
    logic [XLEN-1:0]   fwd_data1;
    logic [XLEN-1:0]   fwd_data2;
`endif

    modport master (
        output valid_in, rd_in, reg_write_in, is_load, funct3, alu_result, mem_ack, mem_rdata,
        input  ready_out, mem_read, mem_address, reg_write, reg_address, reg_data, load_fault
`ifdef WB_FORWARD_EN
        , output fwd_addr1, fwd_addr2, fwd_rf1, fwd_rf2
        , input  fwd_data1, fwd_data2
`endif
    );

    modport slave (
        input  valid_in, rd_in, reg_write_in, is_load, funct3, alu_result, mem_ack, mem_rdata,
        output ready_out, mem_read, mem_address, reg_write, reg_address, reg_data, load_fault
`ifdef WB_FORWARD_EN
        , input  fwd_addr1, fwd_addr2, fwd_rf1, fwd_rf2
        , output fwd_data1, fwd_data2
`endif
    );

endinterface

// File: rtl/writeback_unit_load_extend.sv
// Load data alignment: selects the byte/half lane addressed by addr[1:0] and
// sign- or zero-extends it according to funct3.
module load_extend
    import rv32_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      addr,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr, 3'b000} +: 8];
        lane_h = rdata[{addr[1], 4'b0000} +: 16];
        case (funct3)
            F3_LB:   result = {{(XLEN-8){lane_b[7]}}, lane_b};
            F3_LH:   result = {{(XLEN-16){lane_h[15]}}, lane_h};
            F3_LBU:  result = {{(XLEN-8){1'b0}}, lane_b};
            F3_LHU:  result = {{(XLEN-16){1'b0}}, lane_h};
            default: result = rdata;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// RV32I writeback stage: retires one instruction at a time, performs load reads
// with a req/ack handshake and drives the register-file write port. Optional
// write-to-read forwarding is enabled with WB_FORWARD_EN.
module writeback_unit
    import rv32_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic           clk,
    input  logic           rst,
    writeback_unit_if.slave wb
);
    wb_state_t       state;
    logic            wr_q;
    logic [2:0]      f3_q;
    logic [1:0]      alo_q;
    logic [XLEN-1:0] ext_data;

    load_extend #(.XLEN(XLEN)) u_ext (
        .rdata  (wb.mem_rdata),
        .addr   (alo_q),
        .funct3 (f3_q),
        .result (ext_data)
    );

    assign wb.ready_out = (state != LOAD_WAIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            wr_q           <= 1'b0;
            f3_q           <= '0;
            alo_q          <= '0;
            wb.mem_read    <= 1'b0;
            wb.mem_address <= '0;
            wb.reg_write   <= 1'b0;
            wb.reg_address <= '0;
            wb.reg_data    <= '0;
            wb.load_fault  <= 1'b0;
        end else begin
            wb.reg_write  <= 1'b0;
            wb.load_fault <= 1'b0;
            case (state)
                LOAD_WAIT: begin
                    if (wb.mem_ack) begin
                        wb.mem_read  <= 1'b0;
                        wb.reg_data  <= ext_data;
                        wb.reg_write <= wr_q && (wb.reg_address != '0);
                        state        <= WRITE;
                    end
                end
                default: begin
                    // IDLE and WRITE both accept; reg_address doubles as the latched rd.
                    if (wb.valid_in) begin
                        wr_q           <= wb.reg_write_in;
                        f3_q           <= wb.funct3;
                        alo_q          <= wb.alu_result[1:0];
                        wb.reg_address <= wb.rd_in;
                        if (!wb.is_load) begin
                            wb.reg_data  <= wb.alu_result;
                            wb.reg_write <= wb.reg_write_in && (wb.rd_in != '0);
                            state        <= WRITE;
                        end else if (!load_legal(wb.funct3, wb.alu_result[1:0])) begin
                            wb.load_fault <= 1'b1;
                            state         <= IDLE;
                        end else begin
                            wb.mem_read    <= 1'b1;
                            wb.mem_address <= {wb.alu_result[XLEN-1:2], 2'b00};
                            state          <= LOAD_WAIT;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end

`ifdef WB_FORWARD_EN
    // Combinational bypass so a reader in the write cycle sees the new value.
    assign wb.fwd_data1 = (wb.reg_write && wb.reg_address == wb.fwd_addr1 && wb.fwd_addr1 != '0)
                          ? wb.reg_data : wb.fwd_rf1;
    assign wb.fwd_data2 = (wb.reg_write && wb.reg_address == wb.fwd_addr2 && wb.fwd_addr2 != '0)
                          ? wb.reg_data : wb.fwd_rf2;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// Self-checking bench for writeback_unit: directed test-plan scenarios plus
// randomized instructions checked against a behavioural load/write model.
module tb_writeback_unit;
    import rv32_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    writeback_unit_if #(.XLEN(32), .REG_AW(5)) bus();
    writeback_unit #(.XLEN(32), .REG_AW(5)) dut (.clk(clk), .rst(rst), .wb(bus.slave));

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        bit          mr_seen;
        int          mr_idx;
        logic [31:0] maddr;
        bit          maddr_stable;
        bit          ready_bad;
        int          faults;
        int          fault_idx;
        int          writes;
        int          write_idx;
        logic [4:0]  waddr;
        logic [31:0] wdata;
    } obs_t;

    // Reference: what the register file should receive for a load, from the ISA rules.
    function automatic void model_load(input logic [2:0] f3, input logic [31:0] addr,
                                       input logic [31:0] rdata, output bit legal,
                                       output logic [31:0] val);
        logic [31:0] w;
        legal = 1'b1;
        w     = 32'h0;
        case (f3)
            3'b000, 3'b100: begin
                w = (rdata >> (8 * addr[1:0])) & 32'hFF;
                if (f3 == 3'b000 && w >= 32'h80) w = w | 32'hFFFF_FF00;
            end
            3'b001, 3'b101: begin
                legal = (addr % 2) == 0;
                w = (rdata >> (16 * addr[1])) & 32'hFFFF;
                if (f3 == 3'b001 && w >= 32'h8000) w = w | 32'hFFFF_0000;
            end
            3'b010: begin
                legal = (addr % 4) == 0;
                w = rdata;
            end
            default: legal = 1'b0;
        endcase
        val = w;
    endfunction

    task automatic idle_inputs();
        bus.valid_in     = 1'b0;
        bus.rd_in        = '0;
        bus.reg_write_in = 1'b0;
        bus.is_load      = 1'b0;
        bus.funct3       = '0;
        bus.alu_result   = '0;
        bus.mem_ack      = 1'b0;
        bus.mem_rdata    = '0;
`ifdef WB_FORWARD_EN
        bus.fwd_addr1 = '0;
        bus.fwd_addr2 = '0;
        bus.fwd_rf1   = '0;
        bus.fwd_rf2   = '0;
`endif
    endtask

    // Issues one load (called at a negedge) and records what the DUT does over a
    // bounded window; index 0 is the cycle after acceptance.
    task automatic drive_load(input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] rdata, input logic [4:0] rd,
                              input bit wen, input int waits, output obs_t o);
        int wc;
        o = '{default: 0};
        o.fault_idx    = -1;
        o.write_idx    = -1;
        o.mr_idx       = -1;
        o.maddr_stable = 1'b1;
        wc = 0;
        bus.valid_in = 1'b1; bus.is_load = 1'b1; bus.funct3 = f3;
        bus.alu_result = addr; bus.rd_in = rd; bus.reg_write_in = wen;
        @(negedge clk);
        bus.valid_in = 1'b0;
        for (int i = 0; i < waits + 4; i++) begin
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = $urandom;
            if (bus.load_fault) begin o.faults++; o.fault_idx = i; end
            if (bus.reg_write) begin
                o.writes++; o.write_idx = i; o.waddr = bus.reg_address; o.wdata = bus.reg_data;
            end
            if (bus.mem_read) begin
                if (!o.mr_seen) begin
                    o.mr_seen = 1'b1; o.mr_idx = i; o.maddr = bus.mem_address;
                end else if (bus.mem_address !== o.maddr) o.maddr_stable = 1'b0;
                if (bus.ready_out) o.ready_bad = 1'b1;
                if (wc == waits) begin
                    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
                end else wc++;
            end
            @(negedge clk);
        end
        bus.mem_ack = 1'b0;
    endtask

    task automatic test_reset();
        int wr;
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.mem_read, bus.reg_write, bus.load_fault} !== 3'b000)
            $display("FAIL reset_ctrl: got %b want 000", {bus.mem_read, bus.reg_write, bus.load_fault});
        else n_pass++;
        n_checks++;
        if ({bus.reg_address, bus.reg_data, bus.mem_address} !== 69'h0)
            $display("FAIL reset_data: got %h %h %h want 0", bus.reg_address, bus.reg_data, bus.mem_address);
        else n_pass++;
        n_checks++;
        if (bus.ready_out !== 1'b1) $display("FAIL reset_ready: got %b want 1", bus.ready_out);
        else n_pass++;
        rst = 1'b0;
        // Reset in LOAD_WAIT: ack is offered during reset and must be ignored.
        bus.valid_in = 1'b1; bus.is_load = 1'b1; bus.funct3 = F3_LW;
        bus.alu_result = 32'h3000; bus.rd_in = 5'd7; bus.reg_write_in = 1'b1;
        @(negedge clk);
        bus.valid_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.mem_read !== 1'b1) $display("FAIL reset_preload_req: got %b want 1", bus.mem_read);
        else n_pass++;
        rst = 1'b1; bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFE_F00D;
        repeat (2) @(negedge clk);
        rst = 1'b0; bus.mem_ack = 1'b0;
        n_checks++;
        if ({bus.mem_read, bus.reg_write, bus.ready_out} !== 3'b001)
            $display("FAIL reset_loadwait: got %b want 001", {bus.mem_read, bus.reg_write, bus.ready_out});
        else n_pass++;
        wr = 0;
        repeat (5) begin
            bus.mem_ack = 1'b1;
            @(negedge clk);
            if (bus.reg_write) wr++;
        end
        bus.mem_ack = 1'b0;
        n_checks++;
        if (wr != 0) $display("FAIL reset_no_write: got %0d writes want 0", wr);
        else n_pass++;
    endtask

    task automatic test_nonload_burst();
        logic [31:0] vals [3] = '{32'hA, 32'hB, 32'hC};
        for (int i = 0; i < 3; i++) begin
            bus.valid_in = 1'b1; bus.is_load = 1'b0; bus.reg_write_in = 1'b1;
            bus.rd_in = 5'(i + 1); bus.alu_result = vals[i];
            @(negedge clk);
            n_checks++;
            if ({bus.reg_write, bus.reg_address, bus.reg_data} !== {1'b1, 5'(i + 1), vals[i]})
                $display("FAIL burst_%0d: got %b %0d %h want 1 %0d %h", i,
                         bus.reg_write, bus.reg_address, bus.reg_data, i + 1, vals[i]);
            else n_pass++;
        end
        bus.rd_in = 5'd0; bus.alu_result = 32'hFFFF;
        @(negedge clk);
        bus.valid_in = 1'b0;
        n_checks++;
        if (bus.reg_write !== 1'b0) $display("FAIL burst_x0: got %b want 0", bus.reg_write);
        else n_pass++;
        @(negedge clk);
    endtask

    task automatic test_lb();
        obs_t o; bit lg; logic [31:0] ev;
        model_load(F3_LB, 32'h1003, 32'h80FF_0000, lg, ev);
        drive_load(F3_LB, 32'h1003, 32'h80FF_0000, 5'd9, 1'b1, 3, o);
        n_checks++;
        if (o.maddr !== 32'h1000 || !o.maddr_stable || o.mr_idx != 0)
            $display("FAIL lb_req: got addr %h stable %0d idx %0d want 1000 1 0", o.maddr, o.maddr_stable, o.mr_idx);
        else n_pass++;
        n_checks++;
        if (o.ready_bad) $display("FAIL lb_ready: got ready 1 while waiting want 0");
        else n_pass++;
        n_checks++;
        if (o.writes != 1 || o.write_idx != 4 || o.waddr !== 5'd9 || o.wdata !== ev)
            $display("FAIL lb_write: got n%0d @%0d r%0d %h want n1 @4 r9 %h",
                     o.writes, o.write_idx, o.waddr, o.wdata, ev);
        else n_pass++;
    endtask

    task automatic test_lhu_lw();
        obs_t o; bit lg; logic [31:0] ev;
        model_load(F3_LHU, 32'h2002, 32'h8001_1234, lg, ev);
        drive_load(F3_LHU, 32'h2002, 32'h8001_1234, 5'd10, 1'b1, 0, o);
        n_checks++;
        if (o.writes != 1 || o.write_idx != 1 || o.wdata !== ev || ev !== 32'h0000_8001)
            $display("FAIL lhu_write: got n%0d @%0d %h want n1 @1 %h", o.writes, o.write_idx, o.wdata, ev);
        else n_pass++;
        model_load(F3_LW, 32'h2000, 32'h8001_1234, lg, ev);
        drive_load(F3_LW, 32'h2000, 32'h8001_1234, 5'd11, 1'b1, 1, o);
        n_checks++;
        if (o.writes != 1 || o.write_idx != 2 || o.waddr !== 5'd11 || o.wdata !== ev)
            $display("FAIL lw_write: got n%0d @%0d r%0d %h want n1 @2 r11 %h",
                     o.writes, o.write_idx, o.waddr, o.wdata, ev);
        else n_pass++;
    endtask

    task automatic test_faults();
        obs_t o;
        logic [2:0]  f3s [2] = '{F3_LW, 3'b011};
        logic [31:0] ads [2] = '{32'h2002, 32'h2000};
        for (int i = 0; i < 2; i++) begin
            drive_load(f3s[i], ads[i], 32'h1234_5678, 5'd12, 1'b1, 0, o);
            n_checks++;
            if (o.faults != 1 || o.fault_idx != 0 || o.mr_seen || o.writes != 0)
                $display("FAIL fault_%0d: got f%0d @%0d mr%0d w%0d want f1 @0 mr0 w0",
                         i, o.faults, o.fault_idx, o.mr_seen, o.writes);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        obs_t o; bit lg; logic [31:0] ev, a, rd_word;
        logic [2:0] f3; logic [4:0] rd; bit wen, ld; int waits;
        for (int n = 0; n < 40; n++) begin
            ld = $urandom_range(0, 1); f3 = 3'($urandom); a = $urandom;
            rd = 5'($urandom); wen = $urandom_range(0, 3) != 0; waits = $urandom_range(0, 3);
            rd_word = $urandom;
            if (ld) begin
                model_load(f3, a, rd_word, lg, ev);
                drive_load(f3, a, rd_word, rd, wen, waits, o);
                n_checks++;
                if (o.faults != (lg ? 0 : 1) || o.mr_seen != lg ||
                    o.writes != ((lg && wen && rd != 0) ? 1 : 0) ||
                    (lg && o.maddr !== {a[31:2], 2'b00}) ||
                    (o.writes == 1 && (o.wdata !== ev || o.waddr !== rd || o.write_idx != waits + 1)))
                    $display("FAIL rand_load_%0d: f3 %b a %h got f%0d mr%0d w%0d %h want legal %0d %h",
                             n, f3, a, o.faults, o.mr_seen, o.writes, o.wdata, lg, ev);
                else n_pass++;
            end else begin
                bus.valid_in = 1'b1; bus.is_load = 1'b0; bus.rd_in = rd;
                bus.reg_write_in = wen; bus.alu_result = a; bus.mem_ack = $urandom_range(0, 1);
                @(negedge clk);
                bus.valid_in = 1'b0; bus.mem_ack = 1'b0;
                n_checks++;
                if (bus.reg_write !== (wen && rd != 0) ||
                    (wen && rd != 0 && (bus.reg_data !== a || bus.reg_address !== rd)))
                    $display("FAIL rand_alu_%0d: got %b r%0d %h want %b r%0d %h", n,
                             bus.reg_write, bus.reg_address, bus.reg_data, wen && rd != 0, rd, a);
                else n_pass++;
            end
        end
    endtask

`ifdef WB_FORWARD_EN
    task automatic test_forward();
        logic [31:0] r2;
        r2 = $urandom;
        bus.valid_in = 1'b1; bus.is_load = 1'b0; bus.rd_in = 5'd5;
        bus.reg_write_in = 1'b1; bus.alu_result = 32'h1234;
        @(negedge clk);
        bus.valid_in = 1'b0;
        bus.fwd_addr1 = 5'd5; bus.fwd_rf1 = 32'h0; bus.fwd_addr2 = 5'd0; bus.fwd_rf2 = r2;
        #1;
        n_checks++;
        if (bus.fwd_data1 !== 32'h1234) $display("FAIL fwd1: got %h want 00001234", bus.fwd_data1);
        else n_pass++;
        n_checks++;
        if (bus.fwd_data2 !== r2) $display("FAIL fwd2_x0: got %h want %h", bus.fwd_data2, r2);
        else n_pass++;
        @(negedge clk);
        bus.fwd_rf1 = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if (bus.fwd_data1 !== 32'hDEAD_BEEF) $display("FAIL fwd1_idle: got %h want deadbeef", bus.fwd_data1);
        else n_pass++;
    endtask
`endif

    initial begin
        test_reset();
        test_nonload_burst();
        test_lb();
        test_lhu_lw();
        test_faults();
        test_random();
`ifdef WB_FORWARD_EN
        test_forward();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Final stage of the RV32I datapath, sitting directly upstream of `register_file` and driving its single write port. It accepts one retiring instruction at a time, and for loads performs the data-memory read with a request/acknowledge handshake. It then aligns and sign- or zero-extends the returned data and issues a one-cycle register write. Writes to x0 are suppressed.

## Interface
Parameters:
- `XLEN`, 32: data and address width.
- `REG_AW`, 5: register address width.

Ports:
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `valid_in` in 1: retiring instruction present.
- `ready_out` out 1: unit can accept an instruction this cycle.
- `rd_in` in `REG_AW`: destination register.
- `reg_write_in` in 1: instruction writes `rd`.
- `is_load` in 1: instruction is a load.
- `funct3` in 3: load width and sign (LB=000, LH=001, LW=010, LBU=100, LHU=101).
- `alu_result` in `XLEN`: result value, or the effective address for loads.
- `mem_read` out 1: data-memory read request.
- `mem_address` out `XLEN`: word-aligned request address.
- `mem_ack` in 1: read data valid.
- `mem_rdata` in `XLEN`: read word.
- `reg_write` out 1: drives register file `write`.
- `reg_address` out `REG_AW`: drives `inAddress`.
- `reg_data` out `XLEN`: drives `in`.
- `load_fault` out 1: one-cycle pulse for a misaligned or illegal load.

## Operation
- FSM states: IDLE, LOAD_WAIT, WRITE.
- `ready_out` = (state is IDLE or WRITE).
- The instruction is accepted on a rising edge where `valid_in && ready_out`. Its fields (rd, reg_write_in, funct3, address low bits) are latched on acceptance.
- Acceptance, non-load → WRITE, with `reg_data <= alu_result`.
- Acceptance, legal load → LOAD_WAIT.
- Acceptance, illegal load → IDLE, with `load_fault` pulsed for one cycle and no write. A load is illegal when:
  - funct3 is 011, 110 or 111;
  - LH/LHU with addr[0] = 1;
  - LW with addr[1:0] ≠ 0.
- LOAD_WAIT:
  - `mem_read` = 1.
  - `mem_address` = {addr[31:2], 2'b00}, held stable until ack.
  - On the edge with `mem_ack` = 1: capture `load_extend(mem_rdata, addr[1:0], funct3)`, then → WRITE.
- WRITE:
  - `reg_write` = latched reg_write_in && (rd ≠ 0) for exactly this cycle.
  - Next state follows the acceptance rules if `valid_in`, else → IDLE.
- Lane select: byte = rdata[8*addr[1:0] +: 8]; half = rdata[16*addr[1] +: 16].
- LB/LH sign-extend; LBU/LHU zero-extend.
- `mem_ack` outside LOAD_WAIT is ignored.

## Timing
- Reset values:
  - state = IDLE;
  - `mem_read`, `reg_write`, `load_fault` = 0;
  - `reg_address` = 0, `reg_data` = 0, `mem_address` = 0.
- Reset has priority over all inputs.
- Reset during LOAD_WAIT → IDLE at that edge: request dropped, pending write discarded, no write.
- Non-load latency: accepted at edge N, `reg_write` high during cycle N+1.
- Back-to-back non-loads sustain one write per cycle.
- Load latency: accepted at edge N, `mem_read` high from cycle N+1. Ack sampled at edge M, write during cycle M+1.
- Minimum load latency is 2 cycles (ack in the first request cycle).
- `load_fault` rises in cycle N+1 only.
- All outputs are registered except `ready_out`, which is decoded from state.

## Configuration
- `WB_FORWARD_EN`, defined:
  - Adds inputs `fwd_addr1`, `fwd_addr2` (`REG_AW`) and `fwd_rf1`, `fwd_rf2` (`XLEN`, raw register file reads).
  - Adds outputs `fwd_data1`, `fwd_data2` (`XLEN`).
  - `fwd_dataN` = `reg_data` when `reg_write && reg_address == fwd_addrN && fwd_addrN ≠ 0`, else `fwd_rfN`.
  - Purely combinational, so a same-cycle write is visible to readers.
- Undefined: these ports and logic are absent.

## Structure
- Shared package `rv32_pkg` holds:
  - `wb_state_t` enum (IDLE, LOAD_WAIT, WRITE);
  - funct3 load constants `F3_LB`, `F3_LH`, `F3_LW`, `F3_LBU`, `F3_LHU`.
- Sub-module `load_extend`: combinational lane select plus sign/zero extension (inputs rdata, addr[1:0], funct3).

## Test plan
- Reset: assert `rst` for 2 cycles during LOAD_WAIT → `mem_read` = 0 and `reg_write` = 0 at the next negedge, `ready_out` = 1, no write ever issued.
- Non-load burst: rd = 1, 2, 3 with results 0xA, 0xB, 0xC on consecutive cycles → `reg_write` high 3 consecutive cycles with matching address and data. rd = 0 with 0xFFFF → `reg_write` stays 0.
- LB, address 0x1003, rdata 0x80FF_0000, ack after 3 wait cycles → `mem_address` = 0x1000, `ready_out` = 0 while waiting, then write of 0xFFFF_FF80.
- LHU, address 0x2002, rdata 0x8001_1234 → write of 0x0000_8001. LW, address 0x2000 → write of 0x8001_1234.
- LW at address 0x2002, then funct3 = 011 → `load_fault` pulses once each, `mem_read` never asserted, no write.
- With `WB_FORWARD_EN`: write rd = 5 with 0x1234, `fwd_addr1` = 5, `fwd_rf1` = 0 → `fwd_data1` = 0x1234 in the write cycle. `fwd_addr2` = 0 → `fwd_data2` = `fwd_rf2`.
